discrete_latch_bank: RTL and testbench

Parametrised bank of address-decoded discrete output latches for the LVDA, the successor to the fixed per-signal set/reset latch decoders. One decoded command strobe plus an address sets one of `NCH` discrete channels. Each channel is either a level latch, cleared by group reset, or a timed pulse, cleared automatically after a programmable number of timer ticks. It sits between the address/timing decode (`A*DV`, `X3`/`W8`/`Y8`, `PCG2V`) and the discrete output drivers.

---
 rtl/discrete_latch_bank.sv | 66 ++++++
 tb/tb_discrete_latch_bank.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/discrete_latch_bank.sv
// discrete_latch_bank: address-decoded bank of level-latch and timed-pulse discrete outputs.
module discrete_latch_bank #(
    parameter int NCH = 5,
    parameter int AW = 5,
    parameter int BASE = 1,
    parameter logic [NCH-1:0] PULSE_MASK = '0,
    parameter int PULSE_LEN = 4
) (
    input  logic           SIM_CLK,
    input  logic           SIM_RST,
    input  logic           V1,
    input  logic           STB,
    input  logic [AW-1:0]  ADDR,
    input  logic           LRR,
    input  logic           TICK,
    output logic [NCH-1:0] Q,
    output logic [NCH-1:0] QN,
    output logic           HIT,
    output logic           MISS
);
    localparam logic [AW:0] LO = (AW+1)'(BASE);
    localparam logic [AW:0] HI = (AW+1)'(BASE + NCH);
    localparam logic [7:0] LEN = 8'(PULSE_LEN);
    logic [AW:0] addr_x;
    logic [AW:0] off;
    logic qual;
    logic in_range;
    logic [NCH-1:0] set;
    logic [NCH-1:0] q;
    logic [NCH-1:0] q_next;
    logic [7:0] cnt [NCH];
    logic [7:0] cnt_next [NCH];
    assign addr_x = {1'b0, ADDR};
    assign qual = STB & V1;
    assign in_range = (addr_x >= LO) && (addr_x < HI);
    assign off = addr_x - LO;
    // Set beats group clear and tick on its own channel; clear beats tick everywhere.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            set[i] = qual & in_range & (off == (AW+1)'(i));
            cnt_next[i] = set[i] ? (PULSE_MASK[i] ? LEN : 8'd0) :
                          LRR ? 8'd0 :
                          (TICK && cnt[i] != 8'd0) ? cnt[i] - 8'd1 : cnt[i];
            q_next[i] = set[i] ? 1'b1 :
                        LRR ? 1'b0 :
                        (PULSE_MASK[i] && TICK && cnt[i] == 8'd1) ? 1'b0 : q[i];
        end
    end
    always_ff @(posedge SIM_CLK) begin
        if (!SIM_RST) begin
            q <= '0;
            cnt <= '{default: 8'd0};
            HIT <= 1'b0;
            MISS <= 1'b0;
        end else begin
            HIT <= qual & in_range;
            MISS <= qual & ~in_range;
            if (V1) begin
                q <= q_next;
                cnt <= cnt_next;
            end
        end
    end
    assign Q = q;
    assign QN = ~q;
endmodule

// File: tb/tb_discrete_latch_bank.sv
// tb_discrete_latch_bank: scoreboard bench with directed test-plan sequences and random traffic.
module tb_discrete_latch_bank;
    localparam int NCH = 5;
    localparam int AW = 5;
    localparam int BASE = 1;
    localparam int LEN = 4;
    localparam logic [NCH-1:0] PMASK = 5'b10000;

    typedef struct packed {
        logic [NCH-1:0] q;
        logic hit;
        logic miss;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic v1 = 1'b0;
    logic stb = 1'b0;
    logic [AW-1:0] addr = '0;
    logic lrr = 1'b0;
    logic tick = 1'b0;
    logic [NCH-1:0] q;
    logic [NCH-1:0] qn;
    logic hit;
    logic miss;

    int compared = 0;
    int mismatched = 0;
    exp_t sb[$];

    bit m_q [NCH];
    int m_rem [NCH];

    discrete_latch_bank #(
        .NCH(NCH), .AW(AW), .BASE(BASE), .PULSE_MASK(PMASK), .PULSE_LEN(LEN)
    ) dut (
        .SIM_CLK(clk), .SIM_RST(rst_n), .V1(v1), .STB(stb), .ADDR(addr),
        .LRR(lrr), .TICK(tick), .Q(q), .QN(qn), .HIT(hit), .MISS(miss)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", compared);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every post-edge sample has one expected entry queued by the driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("Q", q, e.q);
                check("QN", qn, ~e.q);
                check("HIT", {4'b0, hit}, {4'b0, e.hit});
                check("MISS", {4'b0, miss}, {4'b0, e.miss});
            end
        end
    end

    // Reference: per-channel remaining-tick counts evaluated straight from the rules.
    task automatic step(input bit r, input bit v, input bit s, input int a, input bit l, input bit t);
        exp_t e;
        bit inr;
        @(negedge clk);
        rst_n = r; v1 = v; stb = s; addr = AW'(a); lrr = l; tick = t;
        inr = (a >= BASE) && (a < BASE + NCH);
        e.hit = r && v && s && inr;
        e.miss = r && v && s && !inr;
        if (!r) begin
            for (int i = 0; i < NCH; i++) begin
                m_q[i] = 0;
                m_rem[i] = 0;
            end
        end else if (v) begin
            for (int i = 0; i < NCH; i++) begin
                if (s && a == BASE + i) begin
                    m_q[i] = 1;
                    m_rem[i] = PMASK[i] ? LEN : 0;
                end else if (l) begin
                    m_q[i] = 0;
                    m_rem[i] = 0;
                end else if (PMASK[i] && t && m_rem[i] > 0) begin
                    m_rem[i] = m_rem[i] - 1;
                    if (m_rem[i] == 0) m_q[i] = 0;
                end
            end
        end
        for (int i = 0; i < NCH; i++) e.q[i] = m_q[i];
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 1);
    endtask

    initial begin
        // reset with an active strobe, then a set of channel 2
        step(0, 1, 1, 1, 0, 0);
        step(0, 1, 1, 1, 0, 0);
        step(1, 1, 1, 3, 0, 0);
        idle(1);
        // phase gating and out-of-range addresses
        step(1, 0, 1, 2, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 6, 0, 0);
        step(1, 1, 1, 31, 0, 0);
        // group clear loses to a same-cycle set
        step(1, 1, 1, 1, 0, 0);
        step(1, 1, 1, 2, 0, 0);
        step(1, 1, 1, 3, 1, 0);
        step(1, 1, 0, 0, 1, 0);
        // pulse with a tick on the set cycle
        step(1, 1, 1, 5, 0, 1);
        ticks(3);
        step(1, 0, 0, 0, 0, 1);
        ticks(2);
        // retrigger together with a tick
        step(1, 1, 1, 5, 0, 0);
        ticks(3);
        step(1, 1, 1, 5, 0, 1);
        ticks(5);
        // reset mid-pulse does not resume
        step(1, 1, 1, 5, 0, 0);
        ticks(2);
        step(0, 1, 0, 0, 0, 1);
        ticks(10);
        // LRR together with TICK on a running pulse
        step(1, 1, 1, 5, 0, 0);
        step(1, 1, 0, 0, 1, 1);
        ticks(2);
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 49) != 0,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7)),
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 1) == 1);
        end
        idle(2);
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
